// File: rtl/audipus_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audipus_spi_pkg
//  Purpose  : Shared constants for the SPI register arbiter: register-map
//             addresses, register-file geometry, default widths and FSM
//             state encodings.
//  Revision : 1.0  initial release
// ============================================================================
package audipus_spi_pkg;

    // Default interface widths
    localparam int DEF_ADDR_W   = 7;
    localparam int DEF_DATA_W   = 8;

    // Register-file geometry: 16 entries, addressed by the low 4 address bits
    localparam int NUM_REGS     = 16;
    localparam int REG_IDX_W    = 4;

    // Address map
    localparam int CFG_BASE     = 'h00;   // 0x00-0x0F read/write config
    localparam int STAT_BASE    = 'h10;   // 0x10-0x1F read-only status
    localparam int ERR_CLR_ADDR = 'h7E;   // write clears err_count, reads 0
    localparam int ERR_ADDR     = 'h7F;   // err_count, read-only

    // Arbiter state encoding
    localparam int         STATE_W    = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SPI_ACC = 2'd1;
    localparam logic [1:0] ST_INT_ACC = 2'd2;

endpackage : audipus_spi_pkg
`default_nettype wire

// File: rtl/spi_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_file
//  Purpose  : 16 x DATA_W configuration storage with one write port and a
//             flat output bus (entry k at bits [DATA_W*k +: DATA_W]).
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             i_we          - write enable
//             i_idx         - entry index
//             i_wdata       - write data
//             o_regs        - flat register contents
//  Revision : 1.0  initial release
// ============================================================================
module spi_reg_file
    import audipus_spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_we,
    input  logic [REG_IDX_W-1:0]       i_idx,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [NUM_REGS*DATA_W-1:0] o_regs
);

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
            logic [DATA_W-1:0] r_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_reg <= '0;
                end else if (i_we && (i_idx == REG_IDX_W'(k))) begin
                    r_reg <= i_wdata;
                end
            end

            assign o_regs[k*DATA_W +: DATA_W] = r_reg;
        end
    endgenerate

endmodule : spi_reg_file
`default_nettype wire

// File: rtl/spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_arbiter
//  Purpose  : Arbitrates a register map between an SPI slave front end and
//             an internal requester. SPI strobes are captured in a one-deep
//             pending slot and always win over the internal request. Exactly
//             one register access is performed per SPI_ACC / INT_ACC cycle.
//  Ports    : clk, reset        - clock, asynchronous active-high reset
//             spi_addr/..._stb  - SPI request (write wins if both strobes)
//             spi_read_data     - registered SPI read result
//             int_req/we/addr/wdata, int_gnt, int_rdata, int_rvalid
//                               - internal requester handshake
//             cfg_regs          - flat configuration registers
//             status_in         - flat read-only status bytes
//             err_count         - saturating access-error counter
//  Revision : 1.0  initial release
// ============================================================================
module spi_reg_arbiter
    import audipus_spi_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    // SPI side
    input  logic [ADDR_W-1:0]          spi_addr,
    input  logic                       spi_write_stb,
    input  logic [DATA_W-1:0]          spi_write_data,
    input  logic                       spi_read_stb,
    output logic [DATA_W-1:0]          spi_read_data,
    // Internal requester
    input  logic                       int_req,
    input  logic                       int_we,
    input  logic [ADDR_W-1:0]          int_addr,
    input  logic [DATA_W-1:0]          int_wdata,
    output logic                       int_gnt,
    output logic [DATA_W-1:0]          int_rdata,
    output logic                       int_rvalid,
    // Register map
    output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
    input  logic [NUM_REGS*DATA_W-1:0] status_in,
    output logic [DATA_W-1:0]          err_count
);

    localparam int HI_W = ADDR_W - REG_IDX_W;

    // ------------------------------------------------------------------
    // State and pending SPI slot
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic               r_pend_valid;
    logic               r_pend_we;
    logic [ADDR_W-1:0]  r_pend_addr;
    logic [DATA_W-1:0]  r_pend_wdata;

    logic               w_spi_stb;
    logic               w_pend_nxt_valid;
    logic               w_int_req_eff;

    assign w_spi_stb = spi_write_stb | spi_read_stb;

    // A strobe in any state loads the slot; SPI_ACC consumes it unless a new
    // strobe reloads it in that same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_we    <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_wdata <= '0;
        end else if (w_spi_stb) begin
            r_pend_valid <= 1'b1;
            r_pend_we    <= spi_write_stb;
            r_pend_addr  <= spi_addr;
            r_pend_wdata <= spi_write_data;
        end else if (r_state == ST_SPI_ACC) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Slot occupancy as it will be at the start of the next cycle.
    assign w_pend_nxt_valid = w_spi_stb | (r_pend_valid & (r_state != ST_SPI_ACC));

    // The int_req seen during INT_ACC is the one being granted right now;
    // only a request still high after the grant counts as a new one.
    assign w_int_req_eff = int_req & (r_state != ST_INT_ACC);

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_pend_nxt_valid) begin
            w_state_nxt = ST_SPI_ACC;
        end else if (w_int_req_eff) begin
            w_state_nxt = ST_INT_ACC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Access multiplexer: one access per active cycle
    // ------------------------------------------------------------------
    logic               w_acc_en;
    logic               w_acc_we;
    logic [ADDR_W-1:0]  w_acc_addr;
    logic [DATA_W-1:0]  w_acc_wdata;

    always_comb begin
        w_acc_en    = 1'b0;
        w_acc_we    = 1'b0;
        w_acc_addr  = '0;
        w_acc_wdata = '0;
        case (r_state)
            ST_SPI_ACC: begin
                w_acc_en    = 1'b1;
                w_acc_we    = r_pend_we;
                w_acc_addr  = r_pend_addr;
                w_acc_wdata = r_pend_wdata;
            end
            ST_INT_ACC: begin
                w_acc_en    = 1'b1;
                w_acc_we    = int_we;
                w_acc_addr  = int_addr;
                w_acc_wdata = int_wdata;
            end
            default: begin
                w_acc_en    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                 w_is_cfg;
    logic                 w_is_stat;
    logic                 w_is_err_clr;
    logic                 w_is_err;
    logic [REG_IDX_W-1:0] w_idx;

    assign w_idx        = w_acc_addr[REG_IDX_W-1:0];
    assign w_is_cfg     = (w_acc_addr[ADDR_W-1:REG_IDX_W] == HI_W'(CFG_BASE  >> REG_IDX_W));
    assign w_is_stat    = (w_acc_addr[ADDR_W-1:REG_IDX_W] == HI_W'(STAT_BASE >> REG_IDX_W));
    assign w_is_err_clr = (w_acc_addr == ADDR_W'(ERR_CLR_ADDR));
    assign w_is_err     = (w_acc_addr == ADDR_W'(ERR_ADDR));

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic w_cfg_we;

    assign w_cfg_we = w_acc_en & w_acc_we & w_is_cfg;

    spi_reg_file #(
        .DATA_W  (DATA_W)
    ) u_reg_file (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_cfg_we),
        .i_idx   (w_idx),
        .i_wdata (w_acc_wdata),
        .o_regs  (cfg_regs)
    );

    // ------------------------------------------------------------------
    // Read data mux (err_count is read before this cycle's update)
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0][DATA_W-1:0] w_cfg_arr;
    logic [NUM_REGS-1:0][DATA_W-1:0] w_stat_arr;
    logic [DATA_W-1:0]               w_rdata;

    assign w_cfg_arr  = cfg_regs;
    assign w_stat_arr = status_in;

    always_comb begin
        w_rdata = '0;
        if (w_is_cfg) begin
            w_rdata = w_cfg_arr[w_idx];
        end else if (w_is_stat) begin
            w_rdata = w_stat_arr[w_idx];
        end else if (w_is_err) begin
            w_rdata = err_count;
        end
    end

    // ------------------------------------------------------------------
    // Error counter
    // ------------------------------------------------------------------
    logic w_err_clr;
    logic w_err_inc;

    assign w_err_clr = w_acc_en & w_acc_we & w_is_err_clr;
    assign w_err_inc = w_acc_en & w_acc_we & ~w_is_cfg & ~w_is_err_clr;

    logic [DATA_W-1:0] r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err_clr) begin
            r_err_count <= '0;
        end else if (w_err_inc && (r_err_count != {DATA_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;

    // ------------------------------------------------------------------
    // Read results
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_spi_rdata;
    logic [DATA_W-1:0] r_int_rdata;
    logic              r_int_rvalid;
    logic              w_int_rd;

    assign w_int_rd = (r_state == ST_INT_ACC) & ~int_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spi_rdata <= '0;
        end else if ((r_state == ST_SPI_ACC) && !r_pend_we) begin
            r_spi_rdata <= w_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_int_rdata  <= '0;
            r_int_rvalid <= 1'b0;
        end else begin
            r_int_rvalid <= w_int_rd;
            if (w_int_rd) begin
                r_int_rdata <= w_rdata;
            end
        end
    end

    assign spi_read_data = r_spi_rdata;
    assign int_rdata     = r_int_rdata;
    assign int_rvalid    = r_int_rvalid;
    assign int_gnt       = (r_state == ST_INT_ACC);

endmodule : spi_reg_arbiter
`default_nettype wire

// File: tb/tb_spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_arbiter
//  Purpose  : Directed self-checking bench for spi_reg_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_reg_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [6:0]   spi_addr;
    logic         spi_write_stb;
    logic [7:0]   spi_write_data;
    logic         spi_read_stb;
    logic [7:0]   spi_read_data;
    logic         int_req;
    logic         int_we;
    logic [6:0]   int_addr;
    logic [7:0]   int_wdata;
    logic         int_gnt;
    logic [7:0]   int_rdata;
    logic         int_rvalid;
    logic [127:0] cfg_regs;
    logic [127:0] status_in;
    logic [7:0]   err_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    spi_reg_arbiter #(
        .ADDR_W         (7),
        .DATA_W         (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_addr       (spi_addr),
        .spi_write_stb  (spi_write_stb),
        .spi_write_data (spi_write_data),
        .spi_read_stb   (spi_read_stb),
        .spi_read_data  (spi_read_data),
        .int_req        (int_req),
        .int_we         (int_we),
        .int_addr       (int_addr),
        .int_wdata      (int_wdata),
        .int_gnt        (int_gnt),
        .int_rdata      (int_rdata),
        .int_rvalid     (int_rvalid),
        .cfg_regs       (cfg_regs),
        .status_in      (status_in),
        .err_count      (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe, then one more cycle: the access result is visible on return.
    task automatic spi_access(input logic we, input logic [6:0] a, input logic [7:0] d);
        spi_addr       = a;
        spi_write_data = d;
        spi_write_stb  = we;
        spi_read_stb   = ~we;
        tick();
        spi_write_stb  = 1'b0;
        spi_read_stb   = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (cfg_regs !== 128'h0) $display("FAIL rst_cfg: got %h expected 0", cfg_regs); else n_pass++;
        n_checks++; if (err_count !== 8'h00) $display("FAIL rst_err: got %h expected 00", err_count); else n_pass++;
        n_checks++; if (spi_read_data !== 8'h00) $display("FAIL rst_spi_rd: got %h expected 00", spi_read_data); else n_pass++;
        n_checks++; if (int_rdata !== 8'h00) $display("FAIL rst_int_rd: got %h expected 00", int_rdata); else n_pass++;
        n_checks++; if ({int_gnt, int_rvalid} !== 2'b00) $display("FAIL rst_pulses: got %b expected 00", {int_gnt, int_rvalid}); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_spi_rw();
        spi_access(1'b1, 7'h03, 8'h5A);
        n_checks++; if (cfg_regs[31:24] !== 8'h5A) $display("FAIL spi_wr_cfg3: got %h expected 5a", cfg_regs[31:24]); else n_pass++;
        spi_access(1'b0, 7'h03, 8'h00);
        n_checks++; if (spi_read_data !== 8'h5A) $display("FAIL spi_rd_cfg3: got %h expected 5a", spi_read_data); else n_pass++;
    endtask

    task automatic test_priority();
        int_req = 1'b1; int_we = 1'b1; int_addr = 7'h04; int_wdata = 8'h11;
        spi_addr = 7'h10; spi_read_stb = 1'b1;
        tick();
        spi_read_stb = 1'b0;
        n_checks++; if (int_gnt !== 1'b0) $display("FAIL prio_no_gnt: got %b expected 0", int_gnt); else n_pass++;
        tick();
        n_checks++; if (spi_read_data !== 8'hC3) $display("FAIL prio_stat_rd: got %h expected c3", spi_read_data); else n_pass++;
        n_checks++; if (int_gnt !== 1'b1) $display("FAIL prio_gnt: got %b expected 1", int_gnt); else n_pass++;
        int_req = 1'b0;
        tick();
        n_checks++; if (cfg_regs[39:32] !== 8'h11) $display("FAIL prio_int_wr: got %h expected 11", cfg_regs[39:32]); else n_pass++;
        n_checks++; if (int_gnt !== 1'b0) $display("FAIL prio_gnt_drop: got %b expected 0", int_gnt); else n_pass++;
    endtask

    task automatic test_spi_during_int();
        int_req = 1'b1; int_we = 1'b1; int_addr = 7'h05; int_wdata = 8'h77;
        tick();
        n_checks++; if (int_gnt !== 1'b1) $display("FAIL dur_gnt: got %b expected 1", int_gnt); else n_pass++;
        int_req = 1'b0;
        spi_addr = 7'h06; spi_write_data = 8'h99; spi_write_stb = 1'b1;
        tick();
        spi_write_stb = 1'b0;
        n_checks++; if (int_gnt !== 1'b0) $display("FAIL dur_spi_acc_gnt: got %b expected 0", int_gnt); else n_pass++;
        n_checks++; if (cfg_regs[47:40] !== 8'h77) $display("FAIL dur_int_wr: got %h expected 77", cfg_regs[47:40]); else n_pass++;
        tick();
        n_checks++; if (cfg_regs[55:48] !== 8'h99) $display("FAIL dur_spi_wr: got %h expected 99", cfg_regs[55:48]); else n_pass++;
    endtask

    task automatic test_int_read();
        int_req = 1'b1; int_we = 1'b0; int_addr = 7'h05;
        tick();
        n_checks++; if ({int_gnt, int_rvalid} !== 2'b10) $display("FAIL intrd_gnt: got %b expected 10", {int_gnt, int_rvalid}); else n_pass++;
        int_req = 1'b0;
        tick();
        n_checks++; if ({int_gnt, int_rvalid} !== 2'b01) $display("FAIL intrd_rvalid: got %b expected 01", {int_gnt, int_rvalid}); else n_pass++;
        n_checks++; if (int_rdata !== 8'h77) $display("FAIL intrd_data: got %h expected 77", int_rdata); else n_pass++;
        tick();
        n_checks++; if (int_rvalid !== 1'b0) $display("FAIL intrd_pulse: got %b expected 0", int_rvalid); else n_pass++;
        n_checks++; if (int_rdata !== 8'h77) $display("FAIL intrd_hold: got %h expected 77", int_rdata); else n_pass++;
    endtask

    task automatic test_both_strobes();
        spi_addr = 7'h07; spi_write_data = 8'h3C;
        spi_write_stb = 1'b1; spi_read_stb = 1'b1;
        tick();
        spi_write_stb = 1'b0; spi_read_stb = 1'b0;
        tick();
        n_checks++; if (cfg_regs[63:56] !== 8'h3C) $display("FAIL both_wr: got %h expected 3c", cfg_regs[63:56]); else n_pass++;
        n_checks++; if (spi_read_data !== 8'hC3) $display("FAIL both_no_rd: got %h expected c3", spi_read_data); else n_pass++;
    endtask

    task automatic test_err_count();
        spi_access(1'b1, 7'h12, 8'hAA);
        n_checks++; if (err_count !== 8'h01) $display("FAIL err_first: got %h expected 01", err_count); else n_pass++;
        // Remaining 299 writes back-to-back: the slot reloads every cycle.
        spi_addr = 7'h12; spi_write_data = 8'hAA; spi_write_stb = 1'b1;
        for (int i = 0; i < 299; i++) tick();
        spi_write_stb = 1'b0;
        tick();
        n_checks++; if (err_count !== 8'hFF) $display("FAIL err_sat: got %h expected ff", err_count); else n_pass++;
        spi_access(1'b0, 7'h7F, 8'h00);
        n_checks++; if (spi_read_data !== 8'hFF) $display("FAIL err_rd: got %h expected ff", spi_read_data); else n_pass++;
        spi_access(1'b1, 7'h7E, 8'h55);
        n_checks++; if (err_count !== 8'h00) $display("FAIL err_clr: got %h expected 00", err_count); else n_pass++;
        spi_access(1'b0, 7'h7E, 8'h00);
        n_checks++; if (spi_read_data !== 8'h00) $display("FAIL err_clr_rd: got %h expected 00", spi_read_data); else n_pass++;
    endtask

    task automatic test_unmapped();
        spi_access(1'b1, 7'h40, 8'h12);
        n_checks++; if (err_count !== 8'h01) $display("FAIL unm_wr_err: got %h expected 01", err_count); else n_pass++;
        spi_access(1'b0, 7'h03, 8'h00);
        n_checks++; if (spi_read_data !== 8'h5A) $display("FAIL unm_pre_rd: got %h expected 5a", spi_read_data); else n_pass++;
        spi_access(1'b0, 7'h40, 8'h00);
        n_checks++; if (spi_read_data !== 8'h00) $display("FAIL unm_rd: got %h expected 00", spi_read_data); else n_pass++;
        n_checks++; if (err_count !== 8'h01) $display("FAIL unm_rd_err: got %h expected 01", err_count); else n_pass++;
    endtask

    task automatic test_reset_mid_int();
        int_req = 1'b1; int_we = 1'b1; int_addr = 7'h03; int_wdata = 8'hEE;
        tick();
        n_checks++; if (int_gnt !== 1'b1) $display("FAIL rmid_gnt: got %b expected 1", int_gnt); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (int_gnt !== 1'b0) $display("FAIL rmid_gnt_off: got %b expected 0", int_gnt); else n_pass++;
        n_checks++; if (cfg_regs !== 128'h0) $display("FAIL rmid_cfg: got %h expected 0", cfg_regs); else n_pass++;
        n_checks++; if ({err_count, spi_read_data, int_rdata} !== 24'h0) $display("FAIL rmid_outs: got %h expected 000000", {err_count, spi_read_data, int_rdata}); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (cfg_regs[31:24] !== 8'h00) $display("FAIL rmid_no_wr: got %h expected 00", cfg_regs[31:24]); else n_pass++;
        reset = 1'b0;
        n_checks++; if (int_gnt !== 1'b0) $display("FAIL rmid_idle: got %b expected 0", int_gnt); else n_pass++;
        tick();
        n_checks++; if (int_gnt !== 1'b1) $display("FAIL rmid_regrant: got %b expected 1", int_gnt); else n_pass++;
        int_req = 1'b0;
        tick();
        n_checks++; if (cfg_regs[31:24] !== 8'hEE) $display("FAIL rmid_wr: got %h expected ee", cfg_regs[31:24]); else n_pass++;
    endtask

    initial begin
        reset          = 1'b1;
        spi_addr       = '0;
        spi_write_stb  = 1'b0;
        spi_write_data = '0;
        spi_read_stb   = 1'b0;
        int_req        = 1'b0;
        int_we         = 1'b0;
        int_addr       = '0;
        int_wdata      = '0;
        status_in      = '0;
        status_in[7:0] = 8'hC3;

        test_reset();
        test_spi_rw();
        test_priority();
        test_spi_during_int();
        test_int_read();
        test_both_strobes();
        test_err_count();
        test_unmapped();
        test_reset_mid_int();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_spi_reg_arbiter
`default_nettype wire
